ctrl_multiciclo: RTL and testbench

Multicycle main control unit for the MIPS datapath. A Moore state machine with a few Mealy handshake outputs. It sequences fetch, decode, execute, memory and write-back for R-type, lw, sw, beq, j and addi, and drives every datapath enable. Its `ALUOp` output feeds the ALU-control stage directly, which combines it with `funct` to select the ALU operation.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/ctrl_multiciclo.sv | 147 ++++++++++++++
 tb/tb_ctrl_multiciclo.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, ALU operation codes and control-FSM state encodings
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Shared with the ALU-control stage.
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_e;

endpackage

// File: rtl/ctrl_multiciclo.sv
// rtl/ctrl_multiciclo.sv - multicycle MIPS main control FSM
module ctrl_multiciclo
    import mips_pkg::*;
#(
    parameter bit ADDR_WAIT_EN = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUOp,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_e state_q, state_d;
    logic   rdy;

    // The branch zero flag is consumed by the PC write logic, not here.
    logic unused_zero;
    assign unused_zero = zero;

    assign rdy   = ADDR_WAIT_EN ? mem_ready : 1'b1;
    assign state = state_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = S_IDLE;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = ALUOP_ADD;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = rdy;
                PCWrite = rdy;
                state_d = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALU precomputes PC + (imm << 2) for a possible branch.
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = rdy ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = rdy;
                state_d    = rdy ? S_FETCH : S_MEM_WRITE;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_RTYPE;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// tb/tb_ctrl_multiciclo.sv - directed scoreboard bench for ctrl_multiciclo
module tb_ctrl_multiciclo;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, RegWrite, RegDst, ALUSrcA, instr_done, illegal_op;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] state;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, srca;
        logic [1:0] srcb, pcsrc;
        logic [2:0] aluop;
        logic       done, ill;
    } outs_t;

    typedef struct {
        string      tag;
        logic [3:0] st;
        outs_t      o;
    } exp_t;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;
    localparam logic [5:0] BAD = 6'b111111;

    outs_t obs;
    exp_t  sb[$];
    int    n_vec  = 0;
    int    n_fail = 0;

    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                  RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp, instr_done, illegal_op};

    ctrl_multiciclo #(.ADDR_WAIT_EN(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
        .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
    );

    always #5 clock = ~clock;

    // Output table transcribed from the state descriptions.
    function automatic outs_t exp_outs(input logic [3:0] st, input logic mr, input logic [5:0] op);
        outs_t o;
        o = '0;
        case (st)
            4'd1:  begin o.mrd = 1; o.srcb = 2'b01; o.irw = mr; o.pcw = mr; end
            4'd2:  begin
                o.srcb = 2'b11;
                o.ill  = !(op == R || op == LW || op == SW || op == BEQ || op == J || op == ADDI);
            end
            4'd3:  begin o.srca = 1; o.srcb = 2'b10; end
            4'd4:  begin o.mrd = 1; o.iord = 1; end
            4'd5:  begin o.rw = 1; o.m2r = 1; o.done = 1; end
            4'd6:  begin o.mwr = 1; o.iord = 1; o.done = mr; end
            4'd7:  begin o.srca = 1; o.aluop = 3'b010; end
            4'd8:  begin o.rw = 1; o.rdst = 1; o.done = 1; end
            4'd9:  begin o.srca = 1; o.aluop = 3'b001; o.pcwc = 1; o.pcsrc = 2'b01; o.done = 1; end
            4'd10: begin o.pcw = 1; o.pcsrc = 2'b10; o.done = 1; end
            4'd11: begin o.srca = 1; o.srcb = 2'b10; end
            4'd12: begin o.rw = 1; o.done = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic step(input string tag, input logic mr, input logic [5:0] op, input logic [3:0] st);
        exp_t e;
        mem_ready = mr;
        opcode    = op;
        sb.push_back('{tag, st, exp_outs(st, mr, op)});
        @(negedge clock);
        e = sb.pop_front();
        chk({e.tag, ".state"}, 32'(state), 32'(e.st));
        chk({e.tag, ".outs"}, 32'(obs), 32'(e.o));
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        mem_ready = 1'b0;
        opcode    = 6'b0;
        zero      = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) step("rst_hold", 1'b1, SW, 4'd0);
        reset_n = 1'b1;
        step("rst_idle", 1'b1, R, 4'd0);

        step("r_fetch", 1'b1, R, 4'd1);
        step("r_dec",   1'b1, R, 4'd2);
        step("r_exec",  1'b1, R, 4'd7);
        step("r_wb",    1'b1, R, 4'd8);

        step("lw_fetch", 1'b1, LW, 4'd1);
        step("lw_dec",   1'b1, LW, 4'd2);
        step("lw_addr",  1'b1, LW, 4'd3);
        step("lw_rd0",   1'b0, LW, 4'd4);
        step("lw_rd1",   1'b0, LW, 4'd4);
        step("lw_rd2",   1'b1, LW, 4'd4);
        step("lw_wb",    1'b1, LW, 4'd5);

        step("sw_fstall", 1'b0, SW, 4'd1);
        step("sw_fetch",  1'b1, SW, 4'd1);
        step("sw_dec",    1'b1, SW, 4'd2);
        step("sw_addr",   1'b1, SW, 4'd3);
        step("sw_wstall", 1'b0, SW, 4'd6);
        step("sw_write",  1'b1, SW, 4'd6);

        step("beq_fetch", 1'b1, BEQ, 4'd1);
        step("beq_dec",   1'b1, BEQ, 4'd2);
        step("beq_br",    1'b1, BEQ, 4'd9);

        step("j_fetch", 1'b1, J, 4'd1);
        step("j_dec",   1'b1, J, 4'd2);
        step("j_jump",  1'b1, J, 4'd10);

        step("addi_fetch", 1'b1, ADDI, 4'd1);
        step("addi_dec",   1'b1, ADDI, 4'd2);
        step("addi_exec",  1'b1, ADDI, 4'd11);
        step("addi_wb",    1'b1, ADDI, 4'd12);

        step("ill_fetch", 1'b1, BAD, 4'd1);
        step("ill_dec",   1'b1, BAD, 4'd2);

        step("swr_fetch", 1'b1, SW, 4'd1);
        step("swr_dec",   1'b1, SW, 4'd2);
        step("swr_addr",  1'b1, SW, 4'd3);
        step("swr_wait",  1'b0, SW, 4'd6);
        chk("swr_pre_mwr", 32'(MemWrite), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("swr_abort_state", 32'(state), 32'd0);
        chk("swr_abort_mwr",   32'(MemWrite), 32'd0);
        chk("swr_abort_done",  32'(instr_done), 32'd0);
        chk("swr_abort_outs",  32'(obs), 32'd0);
        @(posedge clock);
        #1;
        step("swr_hold", 1'b1, SW, 4'd0);
        reset_n = 1'b1;
        step("swr_idle",  1'b1, R, 4'd0);
        step("swr_fetch2", 1'b1, R, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
